// File: rtl/radix2_sdf_if.sv
// Streaming port bundle for one radix-2 single-delay-feedback FFT stage.
// The source (master) supplies samples, flush and the twiddle requested by
// tw_idx; the stage (slave) returns registered output samples.
interface radix2_sdf_if #(
  parameter int DW    = 24,
  parameter int TW    = 16,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic          in_valid;
  logic [DW-1:0] din_r;
  logic [DW-1:0] din_i;
  logic          flush;
  logic [TW-1:0] w_r;
  logic [TW-1:0] w_i;
  logic [AW-1:0] tw_idx;
  logic          out_valid;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;

  modport master (
    output in_valid, din_r, din_i, flush, w_r, w_i,
    input  tw_idx, out_valid, out_r, out_i
  );

  modport slave (
    input  in_valid, din_r, din_i, flush, w_r, w_i,
    output tw_idx, out_valid, out_r, out_i
  );
endinterface

// File: rtl/radix2_sdf_stage.sv
// Radix-2 single-delay-feedback FFT stage (stage size 2*DEPTH).
// First half of a frame fills the delay line, second half runs the
// butterfly (sum out, difference back into the line), and the next frame's
// first half streams the stored differences out through the twiddle multiply.
// Optional macro RADIX2_SAT_EN: saturate every reduction to DW bits instead
// of wrapping.
module radix2_sdf_stage #(
  parameter int DW    = 24,
  parameter int TW    = 16,
  parameter int FRAC  = 8,
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  radix2_sdf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Wide enough for a full complex product sum; add/sub also fit exactly.
  localparam int PW = DW + TW + 1;
  localparam logic [CW-1:0] LAST_FILL = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_BFLY = CW'(2 * DEPTH - 1);

`ifdef RADIX2_SAT_EN
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {FILL0, BFLY, FILL_P} state_t;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } cplx_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] addr;
  logic          beat;
  logic          out_vld_nxt;
  cplx_t         mem [DEPTH];
  cplx_t         head, in_s, sum, diff, prod, wr_data, res;
  logic signed [PW-1:0] m_r, m_i;

  function automatic logic signed [PW-1:0] sx_d(input logic [DW-1:0] v);
    return {{(PW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] sx_t(input logic [TW-1:0] v);
    return {{(PW-TW){v[TW-1]}}, v};
  endfunction

  // Bring a wide signed result back to DW bits (saturate or wrap).
  function automatic logic [DW-1:0] reduce(input logic signed [PW-1:0] x);
`ifdef RADIX2_SAT_EN
    if (x > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (x < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return x[DW-1:0];
`else
    return x[DW-1:0];
`endif
  endfunction

  // Delay line is read and written at the same slot every beat.
  assign addr       = cnt[AW-1:0];
  assign bus.tw_idx = addr;
  assign head       = mem[addr];

  // Butterfly and twiddle datapath; flush beats present a zero sample.
  always_comb begin
    in_s.r = bus.in_valid ? bus.din_r : '0;
    in_s.i = bus.in_valid ? bus.din_i : '0;
    sum.r  = reduce(sx_d(head.r) + sx_d(in_s.r));
    sum.i  = reduce(sx_d(head.i) + sx_d(in_s.i));
    diff.r = reduce(sx_d(head.r) - sx_d(in_s.r));
    diff.i = reduce(sx_d(head.i) - sx_d(in_s.i));
    m_r    = sx_d(head.r) * sx_t(bus.w_r) - sx_d(head.i) * sx_t(bus.w_i);
    m_i    = sx_d(head.r) * sx_t(bus.w_i) + sx_d(head.i) * sx_t(bus.w_r);
    prod.r = reduce(m_r >>> FRAC);
    prod.i = reduce(m_i >>> FRAC);
  end

  // Next state, counter, delay-line write data and output selection.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    out_vld_nxt = 1'b0;
    wr_data     = in_s;
    res         = sum;
    beat        = bus.in_valid || (bus.flush && state == FILL_P);
    case (state)
      FILL0: begin
        if (beat) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST_FILL) state_nxt = BFLY;
        end
      end
      FILL_P: begin
        if (beat) begin
          out_vld_nxt = 1'b1;
          res         = prod;
          if (!bus.in_valid && cnt == LAST_FILL) begin
            // Flush finished draining: stage becomes unprimed again.
            state_nxt = FILL0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == LAST_FILL) state_nxt = BFLY;
          end
        end
      end
      BFLY: begin
        if (beat) begin
          out_vld_nxt = 1'b1;
          res         = sum;
          wr_data     = diff;
          cnt_nxt     = cnt + CW'(1);
          if (cnt == LAST_BFLY) state_nxt = FILL_P;
        end
      end
      default: state_nxt = FILL0;
    endcase
  end

  // State and frame counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Delay-line write on every accepted beat.
  // NOTE: the delay line is deliberately not reset; FILL0 refills every slot
  // before any of it can reach the output, so reset would only cost logic.
  always_ff @(posedge clk) begin
    if (!rst && beat) mem[addr] <= wr_data;
  end

  // Registered output; sample holds while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_r     <= '0;
      bus.out_i     <= '0;
    end else begin
      bus.out_valid <= out_vld_nxt;
      if (out_vld_nxt) begin
        bus.out_r <= res.r;
        bus.out_i <= res.i;
      end
    end
  end
endmodule

// File: tb/tb_radix2_sdf_stage.sv
// Directed scoreboard bench for radix2_sdf_stage (DW=24, TW=16, FRAC=8,
// DEPTH=4). Stimulus pushes hand-computed expected outputs; a negedge
// monitor pops and compares whenever out_valid is high and checks that the
// output holds otherwise.
module tb_radix2_sdf_stage;
  localparam int DW    = 24;
  localparam int TW    = 16;
  localparam int FRAC  = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } samp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  samp_t exp_q[$];
  samp_t hold;
  samp_t mon_e;
  bit    mon_en = 1'b0;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  radix2_sdf_if #(.DW(DW), .TW(TW), .DEPTH(DEPTH)) bus ();

  radix2_sdf_stage #(.DW(DW), .TW(TW), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef RADIX2_SAT_EN
  localparam int MAX_SUM = 32'h7FFFFF;
`else
  localparam int MAX_SUM = 32'hFFFFFE;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_r", 64'(bus.out_r), 64'(mon_e.r));
          check("out_i", 64'(bus.out_i), 64'(mon_e.i));
          hold = mon_e;
        end
      end else begin
        check("hold_r", 64'(bus.out_r), 64'(hold.r));
        check("hold_i", 64'(bus.out_i), 64'(hold.i));
      end
      if (rst) hold = '0;
    end
  end

  // One cycle of stimulus; idx<0 skips the twiddle-index check.
  task automatic send(input bit v, input bit fl, input int r, input int i,
                      input int idx, input bit ev, input int er, input int ei);
    samp_t e;
    bus.in_valid = v;
    bus.flush    = fl;
    bus.din_r    = DW'(r);
    bus.din_i    = DW'(i);
    if (idx >= 0) check("tw_idx", 64'(bus.tw_idx), 64'(idx));
    if (ev) begin
      e.r = DW'(er);
      e.i = DW'(ei);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!ev) check("no_out_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic idle(input int n, input bit fl);
    for (int c = 0; c < n; c++) send(1'b0, fl, 0, 0, -1, 1'b0, 0, 0);
  endtask

  // Real inputs 1..8; first frame is unprimed, later frames emit -4 heads.
  task automatic frame_real(input bit first, input bit gaps, input bit fl);
    for (int k = 1; k <= 8; k++) begin
      if (gaps && (k == 3 || k == 7)) idle(3, fl);
      if (k <= 4) send(1'b1, fl, k, 0, k - 1, !first, -4, 0);
      else        send(1'b1, fl, k, 0, k - 5, 1'b1, 2 * k - 4, 0);
    end
  endtask

  initial begin
    hold         = '0;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b0;
    bus.din_r    = 24'h000123;
    bus.din_i    = 24'h000045;
    bus.w_r      = 16'd256;
    bus.w_i      = 16'd0;

    // Reset held two cycles with in_valid high.
    repeat (2) begin
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_r", 64'(bus.out_r), 64'd0);
      check("rst_out_i", 64'(bus.out_i), 64'd0);
      check("rst_tw_idx", 64'(bus.tw_idx), 64'd0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    // Frame A: unprimed, then sums 6,8,10,12.
    frame_real(1'b1, 1'b0, 1'b0);

    // Frame B: heads -4 out; butterfly with imaginary parts.
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4)      send(1'b1, 1'b0, k, 3, k - 1, 1'b1, -4, 0);
      else if (k == 5) send(1'b1, 1'b0, 5, 3, 0, 1'b1, 6, 6);
      else             send(1'b1, 1'b0, k, 1, k - 5, 1'b1, 2 * k - 4, 4);
    end

    // Frame C: twiddle (0,-256); heads (-4,0) then (-4,2); max-value butterfly.
    bus.w_r = 16'd0;
    bus.w_i = 16'hFF00;
    send(1'b1, 1'b0, 32'h7FFFFF, 0, 0, 1'b1, 0, 4);
    for (int k = 2; k <= 4; k++) send(1'b1, 1'b0, 32'h7FFFFF, 0, k - 1, 1'b1, 2, 4);
    for (int k = 5; k <= 8; k++) send(1'b1, 1'b0, 32'h7FFFFF, 0, k - 5, 1'b1, MAX_SUM, 0);

    // Two beats of a new frame, then reset discards it.
    bus.w_r = 16'd256;
    bus.w_i = 16'd0;
    send(1'b1, 1'b0, 9, 9, 0, 1'b1, 0, 0);
    send(1'b1, 1'b0, 9, 9, 1, 1'b1, 0, 0);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_tw_idx", 64'(bus.tw_idx), 64'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    // Same frames as A/B-real with 3-cycle gaps.
    frame_real(1'b1, 1'b1, 1'b0);
    frame_real(1'b0, 1'b1, 1'b0);

    // Flush: drain four -4 differences through varied twiddles.
    send(1'b0, 1'b1, 0, 0, 0, 1'b1, -4, 0);
    bus.w_r = 16'd128;
    bus.w_i = 16'd128;
    send(1'b0, 1'b1, 0, 0, 1, 1'b1, -2, -2);
    bus.w_r = 16'd96;
    bus.w_i = 16'hFFE0;
    send(1'b0, 1'b1, 0, 0, 2, 1'b1, -2, 0);
    bus.w_r = 16'd0;
    bus.w_i = 16'hFF00;
    send(1'b0, 1'b1, 0, 0, 3, 1'b1, 0, 4);
    send(1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 0);

    // Back in FILL0: flush held high is ignored / treated as normal beats.
    bus.w_r = 16'd256;
    bus.w_i = 16'd0;
    frame_real(1'b1, 1'b1, 1'b1);

    // Bounded drain of the scoreboard.
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/radix2_sdf_stage.md
RADIX2_SDF_STAGE -- requirements
Module: radix2_sdf_stage

Interface
REQ-001 SHALL have parameter DW, default 24: sample width per real/imag component, signed two's complement.
REQ-002 SHALL have parameter TW, default 16: twiddle width per component, signed, FRAC fractional bits.
REQ-003 SHALL have parameter FRAC, default 8: product right-shift after twiddle multiply.
REQ-004 SHALL have parameter DEPTH, default 32, power of two >= 2: delay-line length L (stage FFT size 2L).
REQ-005 Ports, one per line:
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  synchronous reset, active-high
 in_valid  in  1  sample present on din_r/din_i
 din_r, din_i  in  DW  input sample
 flush  in  1  drain pending differences with zero input
 w_r, w_i  in  TW  twiddle for index tw_idx, valid same cycle
 tw_idx  out  log2(DEPTH)  twiddle index request, combinational from counter
 out_valid  out  1  registered output strobe
 out_r, out_i  out  DW  registered output sample

Function
REQ-006 SHALL keep counter cnt over 0..2L-1, advancing by one per accepted beat and wrapping 2L-1 -> 0.
REQ-007 Accepted beat SHALL be in_valid=1, or flush=1 with in_valid=0 in state FILL_P; flush beats use din=0.
REQ-008 States SHALL be FILL0 (unprimed fill), BFLY, FILL_P (primed fill); reset -> FILL0.
REQ-009 FILL0/FILL_P -> BFLY when a beat is accepted at cnt=L-1; BFLY -> FILL_P when accepted at cnt=2L-1.
REQ-010 FILL0, FILL_P: input SHALL be written to delay line; no beat, no write.
REQ-011 FILL_P: delay-line head h SHALL be output as (h*w)>>>FRAC complex, out_valid=1.
REQ-012 FILL0: out_valid SHALL stay 0 for every beat.
REQ-013 BFLY: with a=head, b=input, output SHALL be a+b and a-b SHALL be written to the delay line.
REQ-014 Delay line SHALL be a circular buffer of L entries, read and written at the same address cnt mod L each beat.
REQ-015 tw_idx SHALL equal cnt mod L; twiddle used only in FILL_P.
REQ-016 Complex multiply SHALL compute full-precision real=h_r*w_r-h_i*w_i, imag=h_r*w_i+h_i*w_r, then arithmetic shift right FRAC (truncate toward -inf), then reduce to DW.
REQ-017 Add/sub SHALL be computed at DW+1 bits then reduced to DW.
REQ-018 Latency SHALL be exactly 1 clock from accepted beat to out_valid; out_valid=0 on cycles with no accepted beat.
REQ-019 out_r/out_i SHALL hold last value when out_valid=0.
REQ-020 Flush SHALL apply only in FILL_P; ignored in FILL0 and BFLY; when flush reaches cnt=L-1 with in_valid=0, state SHALL go to FILL0 and cnt to 0.
REQ-021 in_valid and flush both high SHALL be treated as a normal in_valid beat.

Reset
REQ-022 rst=1 SHALL force state FILL0, cnt=0, out_valid=0, out_r=0, out_i=0, overriding any beat that cycle.
REQ-023 Delay-line contents SHALL NOT be reset; FILL0 gating guarantees stale data never reaches outputs.
REQ-024 Reset mid-frame SHALL discard the frame; first beat after release is cnt=0.

Configuration
REQ-025 Macro RADIX2_SAT_EN defined: every DW reduction (REQ-016, REQ-017) SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-026 RADIX2_SAT_EN undefined: reductions SHALL wrap (keep low DW bits); no saturation logic present.

Verification (DW=24, TW=16, FRAC=8, DEPTH=4)
REQ-027 rst high 2 cycles with in_valid=1 -> out_valid=0, out_r=out_i=0, tw_idx=0.
REQ-028 Real inputs 1..8 gapless, w=(256,0) -> no out_valid for beats 1-4; beats 5-8 out 6,8,10,12; next frame beats 1-4 out -4,-4,-4,-4.
REQ-029 Difference -4 with w=(0,-256) -> out_r=0, out_i=4.
REQ-030 a=b=0x7FFFFF in BFLY -> out_r=0x7FFFFF with RADIX2_SAT_EN, 0xFFFFFE without.
REQ-031 Same frames as REQ-028 with in_valid low for 3 cycles between beats 2 and 3 and beats 6 and 7 -> identical out sequence, out_valid low during gaps.
REQ-032 One frame then flush=1, in_valid=0 for 5 cycles -> 4 differences out, then state FILL0, cnt=0, fifth flush cycle produces no output.
